// File: rtl/mux32_4entradas_reg_if.sv
// Bus bundle for the 4-input datapath selector: select, data inputs, load enable and results.
// MUX32_PARITY_EN adds the registered parity output paridad.
interface mux32_4entradas_reg_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       sel;
  logic [WIDTH-1:0] entradaA;
  logic [WIDTH-1:0] entradaB;
  logic [WIDTH-1:0] entradaC;
  logic [WIDTH-1:0] entradaD;
  logic             en;
  logic [WIDTH-1:0] salida;
  logic [WIDTH-1:0] salida_q;
  logic [1:0]       sel_q;
  logic             cambio;
`ifdef MUX32_PARITY_EN
  logic             paridad;

  modport master (
    output sel, entradaA, entradaB, entradaC, entradaD, en,
    input  salida, salida_q, sel_q, cambio, paridad
  );

  modport slave (
    input  sel, entradaA, entradaB, entradaC, entradaD, en,
    output salida, salida_q, sel_q, cambio, paridad
  );
`else
  modport master (
    output sel, entradaA, entradaB, entradaC, entradaD, en,
    input  salida, salida_q, sel_q, cambio
  );

  modport slave (
    input  sel, entradaA, entradaB, entradaC, entradaD, en,
    output salida, salida_q, sel_q, cambio
  );
`endif
endinterface

// File: rtl/mux32_4entradas_reg.sv
// 4-input selector with a combinational result and a registered copy that tracks select changes.
// Define MUX32_PARITY_EN to add the registered even-parity output paridad.
module mux32_4entradas_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic               clk,
  input logic               rst_n,
  mux32_4entradas_reg_if.slave bus
);

  logic [WIDTH-1:0] salidaComb;
  logic [WIDTH-1:0] salidaQ;
  logic [1:0]       selQ;
  logic             cambioQ;

  // An unknown select must give an unknown result instead of quietly picking an input.
  always_comb begin
    salidaComb = 'x;
    case (bus.sel)
      2'd0:    salidaComb = bus.entradaA;
      2'd1:    salidaComb = bus.entradaB;
      2'd2:    salidaComb = bus.entradaC;
      2'd3:    salidaComb = bus.entradaD;
      default: salidaComb = 'x;
    endcase
  end

  assign bus.salida = salidaComb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      salidaQ <= RESET_VALUE;
      selQ    <= 2'd0;
      cambioQ <= 1'b0;
    end else if (bus.en) begin
      salidaQ <= salidaComb;
      selQ    <= bus.sel;
      cambioQ <= (bus.sel != selQ);
    end else begin
      cambioQ <= 1'b0;
    end
  end

  assign bus.salida_q = salidaQ;
  assign bus.sel_q    = selQ;
  assign bus.cambio   = cambioQ;

`ifdef MUX32_PARITY_EN
  logic paridadQ;

  // Computed from the value being loaded so it always matches salida_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paridadQ <= 1'b0;
    end else if (bus.en) begin
      paridadQ <= ^salidaComb;
    end
  end

  assign bus.paridad = paridadQ;
`endif

endmodule

// File: tb/tb_mux32_4entradas_reg.sv
// Directed-vector bench for mux32_4entradas_reg; expected values are hand-computed constants.
module tb_mux32_4entradas_reg;

  logic clk;
  logic rst_n;
  int   nVectors;
  int   nMiscompares;
  int   selInt;

  mux32_4entradas_reg_if #(.WIDTH(32)) bus ();

  mux32_4entradas_reg #(
    .WIDTH(32),
    .RESET_VALUE(32'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Inputs change between edges; results are sampled 1 ns after the rising edge.
  task automatic clockAndSample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.sel      = 2'd0;
    bus.entradaA = 32'd10;
    bus.entradaB = 32'd20;
    bus.entradaC = 32'd30;
    bus.entradaD = 32'd40;
    #1;
    checkVal("reset salida_q", bus.salida_q, 32'd0);
    checkVal("reset sel_q", {30'd0, bus.sel_q}, 32'd0);
    checkVal("reset cambio", {31'd0, bus.cambio}, 32'd0);

    // Combinational selection, inside a single half period so no edge intervenes
    checkVal("comb sel0", bus.salida, 32'd10);
    bus.sel = 2'd1; #1;
    checkVal("comb sel1", bus.salida, 32'd20);
    bus.sel = 2'd2; #1;
    checkVal("comb sel2", bus.salida, 32'd30);
    bus.sel = 2'd3; #1;
    checkVal("comb sel3", bus.salida, 32'd40);
    selInt  = 4;
    bus.sel = selInt[1:0]; #1;
    checkVal("sel int4 truncated", {30'd0, bus.sel}, 32'd0);
    checkVal("comb sel int4", bus.salida, 32'd10);

    // Release away from an edge, then load D=40
    @(negedge clk);
    rst_n   = 1'b1;
    bus.en  = 1'b1;
    bus.sel = 2'd3;
    clockAndSample();
    checkVal("load D salida_q", bus.salida_q, 32'd40);
    checkVal("load D sel_q", {30'd0, bus.sel_q}, 32'd3);
    checkVal("load D cambio", {31'd0, bus.cambio}, 32'd1);

    // Asynchronous reset mid-cycle
    rst_n = 1'b0; #1;
    checkVal("async rst salida_q", bus.salida_q, 32'd0);
    checkVal("async rst sel_q", {30'd0, bus.sel_q}, 32'd0);
    checkVal("async rst cambio", {31'd0, bus.cambio}, 32'd0);
    bus.sel = 2'd1; #1;
    checkVal("comb during rst", bus.salida, 32'd20);

    @(negedge clk);
    rst_n        = 1'b1;
    bus.sel      = 2'd2;
    bus.entradaC = 32'hDEADBEEF;
    clockAndSample();
    checkVal("load C salida_q", bus.salida_q, 32'hDEADBEEF);
    checkVal("load C sel_q", {30'd0, bus.sel_q}, 32'd2);
    checkVal("load C cambio", {31'd0, bus.cambio}, 32'd1);
    clockAndSample();
    checkVal("same sel cambio", {31'd0, bus.cambio}, 32'd0);
    checkVal("same sel salida_q", bus.salida_q, 32'hDEADBEEF);

    bus.entradaC = 32'h12345678;
    clockAndSample();
    checkVal("data chg salida_q", bus.salida_q, 32'h12345678);
    checkVal("data chg cambio", {31'd0, bus.cambio}, 32'd0);

    bus.sel = 2'd1;
    clockAndSample();
    checkVal("sel 2->1 salida_q", bus.salida_q, 32'd20);
    checkVal("sel 2->1 cambio", {31'd0, bus.cambio}, 32'd1);

    // Hold with en=0 while select and data move
    bus.en       = 1'b0;
    bus.sel      = 2'd3;
    bus.entradaD = 32'hCAFEF00D;
    bus.entradaB = 32'h0BADF00D;
    clockAndSample();
    checkVal("hold salida_q", bus.salida_q, 32'd20);
    checkVal("hold sel_q", {30'd0, bus.sel_q}, 32'd1);
    checkVal("hold cambio", {31'd0, bus.cambio}, 32'd0);
    checkVal("hold comb salida", bus.salida, 32'hCAFEF00D);

    bus.en = 1'b1;
    clockAndSample();
    checkVal("resume salida_q", bus.salida_q, 32'hCAFEF00D);
    checkVal("resume sel_q", {30'd0, bus.sel_q}, 32'd3);
    checkVal("resume cambio", {31'd0, bus.cambio}, 32'd1);

    // First load after reset with sel=0 compares against the cleared sel_q
    rst_n = 1'b0; #1;
    @(negedge clk);
    rst_n   = 1'b1;
    bus.sel = 2'd0;
    clockAndSample();
    checkVal("first load sel0 cambio", {31'd0, bus.cambio}, 32'd0);
    checkVal("first load sel0 salida_q", bus.salida_q, 32'd10);

`ifdef MUX32_PARITY_EN
    bus.entradaA = 32'h00000007;
    clockAndSample();
    checkVal("paridad 0x7", {31'd0, bus.paridad}, 32'd1);
    bus.entradaA = 32'h00000003;
    clockAndSample();
    checkVal("paridad 0x3", {31'd0, bus.paridad}, 32'd0);
    bus.en       = 1'b0;
    bus.entradaA = 32'h00000001;
    clockAndSample();
    checkVal("paridad hold", {31'd0, bus.paridad}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
